// File: rtl/glcd_pkg.sv
// Shared opcodes, geometry and per-half state type for the graphic-LCD bus responder.
// Command decode lives here so every half controller and the top agree on it.
package glcd_pkg;

   localparam int PAGES     = 8;
   localparam int COLS      = 128;
   localparam int HALF_COLS = 64;

   localparam logic [7:0] CMD_OFF        = 8'h3E;
   localparam logic [7:0] CMD_ON         = 8'h3F;
   localparam logic [7:0] CMD_DISP_MASK  = 8'hFF;
   localparam logic [7:0] CMD_SETY       = 8'h40;
   localparam logic [7:0] CMD_SETY_MASK  = 8'hC0;
   localparam logic [7:0] CMD_SETPG      = 8'hB8;
   localparam logic [7:0] CMD_SETPG_MASK = 8'hF8;
   localparam logic [7:0] CMD_START      = 8'hC0;
   localparam logic [7:0] CMD_START_MASK = 8'hC0;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_OFF,
      OP_ON,
      OP_SETY,
      OP_SETPG,
      OP_START
   } op_e;

   typedef struct packed {
      logic [2:0] page;
      logic [5:0] y;
      logic       on;
      logic [5:0] start;
   } half_state_t;

   function automatic op_e decode_cmd(input logic [7:0] b);
      if ((b & CMD_DISP_MASK) == CMD_OFF)   return OP_OFF;
      if ((b & CMD_DISP_MASK) == CMD_ON)    return OP_ON;
      if ((b & CMD_SETPG_MASK) == CMD_SETPG) return OP_SETPG;
      if ((b & CMD_SETY_MASK) == CMD_SETY)  return OP_SETY;
      if ((b & CMD_START_MASK) == CMD_START) return OP_START;
      return OP_NONE;
   endfunction

endpackage

// File: rtl/glcd_bus_responder_if.sv
// Initiator-side LCD bus: strobe, register select, direction, half selects and data.
// The responder uses the slave modport; a bench or host model uses master.
interface glcd_bus_responder_if;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       cs1;
   logic       cs2;
   logic [7:0] lcd_data;
   logic [7:0] lcd_dout;
   logic       lcd_doe;

   modport master (
      output lcd_e, lcd_rs, lcd_rw, cs1, cs2, lcd_data,
      input  lcd_dout, lcd_doe
   );

   modport slave (
      input  lcd_e, lcd_rs, lcd_rw, cs1, cs2, lcd_data,
      output lcd_dout, lcd_doe
   );
endinterface

// File: rtl/glcd_half_ctrl.sv
// One controller half: page/y/on/start-line registers, command decode and y auto-increment.
// en_i is a single-cycle accepted-transaction pulse already qualified by this half's select.
module glcd_half_ctrl
   import glcd_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   input  logic        rs_i,
   input  logic        rw_i,
   input  logic [7:0]  data_i,
   output half_state_t state_o
);

   half_state_t state_q, state_d;
   op_e         op;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      op      = decode_cmd(data_i);
      if (en_i) begin
         if (!rs_i && !rw_i) begin
            case (op)
               OP_OFF:   state_d.on    = 1'b0;
               OP_ON:    state_d.on    = 1'b1;
               OP_SETY:  state_d.y     = data_i[5:0];
               OP_SETPG: state_d.page  = data_i[2:0];
               OP_START: state_d.start = data_i[5:0];
               default:  state_d       = state_q;
            endcase
         end else if (rs_i) begin
            // Data reads and writes both advance y; it wraps 63 -> 0 and page never moves.
            state_d.y = state_q.y + 6'd1;
         end
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= '0;
      else        state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/glcd_bus_responder.sv
// Responder end of the two-controller 128x64 LCD bus: E synchroniser with arming,
// two half controllers, a two-lane frame buffer, read latch and status mux.
module glcd_bus_responder
   import glcd_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int CS_ACTIVE_HIGH = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   glcd_bus_responder_if.slave        bus,
   output logic [1:0]                 disp_on,
   output logic [5:0]                 start_line0,
   output logic [5:0]                 start_line1,
   input  logic [$clog2(PAGES)-1:0]   fb_page,
   input  logic [$clog2(COLS)-1:0]    fb_col,
   output logic [7:0]                 fb_rdata,
   output logic                       txn_strobe,
   output logic                       bad_cmd
);

   localparam int             FILL_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);
   localparam logic           CS_LVL    = (CS_ACTIVE_HIGH != 0);
   localparam int             MEM_DEPTH = PAGES * HALF_COLS;

   logic [SYNC_STAGES-1:0] e_sync_q;
   logic                   e_prev_q;
   logic [FILL_W-1:0]      fill_q;
   logic                   armed_q;
   logic                   e_s, fill_done, e_rise, e_fall;

   assign e_s       = e_sync_q[SYNC_STAGES-1];
   // Edges only count once the synchroniser and the delay flop hold post-reset samples,
   // so an E that was already high at reset release never looks like a rising edge.
   assign fill_done = (fill_q == FILL_DONE);
   assign e_rise    = fill_done &  e_s & ~e_prev_q;
   assign e_fall    = fill_done & ~e_s &  e_prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_sync_q <= '0;
         e_prev_q <= 1'b0;
         fill_q   <= '0;
         armed_q  <= 1'b0;
      end else begin
         e_sync_q <= {e_sync_q[SYNC_STAGES-2:0], bus.lcd_e};
         e_prev_q <= e_s;
         fill_q   <= fill_done ? fill_q : fill_q + 1'b1;
         armed_q  <= armed_q | e_rise;
      end
   end

   logic sel_l, sel_r, accept, is_cmd_wr, is_data_wr, is_data_rd;
   op_e  op;

   assign sel_l      = (bus.cs1 == CS_LVL);
   assign sel_r      = (bus.cs2 == CS_LVL);
   assign accept     = e_fall & armed_q & (sel_l | sel_r);
   assign op         = decode_cmd(bus.lcd_data);
   assign is_cmd_wr  = ~bus.lcd_rs & ~bus.lcd_rw;
   assign is_data_wr =  bus.lcd_rs & ~bus.lcd_rw;
   assign is_data_rd =  bus.lcd_rs &  bus.lcd_rw;

   half_state_t st_l, st_r;

   glcd_half_ctrl u_left (
      .clk     (clk),
      .reset   (reset),
      .en_i    (accept & sel_l),
      .rs_i    (bus.lcd_rs),
      .rw_i    (bus.lcd_rw),
      .data_i  (bus.lcd_data),
      .state_o (st_l)
   );

   glcd_half_ctrl u_right (
      .clk     (clk),
      .reset   (reset),
      .en_i    (accept & sel_r),
      .rs_i    (bus.lcd_rs),
      .rw_i    (bus.lcd_rw),
      .data_i  (bus.lcd_data),
      .state_o (st_r)
   );

   // One byte lane per half so a both-halves write lands in a single cycle.
   logic [7:0] fb_l [MEM_DEPTH];
   logic [7:0] fb_r [MEM_DEPTH];
   logic [8:0] addr_l, addr_r, addr_sb;
   logic       wr_l, wr_r;

   assign addr_l  = {st_l.page, st_l.y};
   assign addr_r  = {st_r.page, st_r.y};
   assign addr_sb = {fb_page, fb_col[5:0]};
   assign wr_l    = accept & sel_l & is_data_wr;
   assign wr_r    = accept & sel_r & is_data_wr;

   // NOTE: the frame buffer is deliberately not reset so it maps onto RAM; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_l) fb_l[addr_l] <= bus.lcd_data;
      if (wr_r) fb_r[addr_r] <= bus.lcd_data;
   end

   logic [7:0] rd_latch_q, fb_rdata_q;
   logic       txn_strobe_q, bad_cmd_q, reset_flag_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_latch_q   <= 8'h00;
         fb_rdata_q   <= 8'h00;
         txn_strobe_q <= 1'b0;
         bad_cmd_q    <= 1'b0;
         reset_flag_q <= 1'b1;
      end else begin
         // Scoreboard read sees the pre-write byte when a bus write hits the same address.
         fb_rdata_q   <= fb_col[6] ? fb_r[addr_sb] : fb_l[addr_sb];
         txn_strobe_q <= accept;
         bad_cmd_q    <= accept & is_cmd_wr & (op == OP_NONE);
         if (accept) reset_flag_q <= 1'b0;
         if (accept && is_data_rd)
            rd_latch_q <= sel_l ? fb_l[addr_l] : fb_r[addr_r];
      end
   end

   half_state_t stat_half;
   logic [7:0]  status;

   assign stat_half    = sel_l ? st_l : st_r;
   assign status       = {2'b00, ~stat_half.on, reset_flag_q, 4'h0};
   assign bus.lcd_doe  = e_s & bus.lcd_rw & (sel_l | sel_r);
   assign bus.lcd_dout = bus.lcd_doe ? (bus.lcd_rs ? rd_latch_q : status) : 8'h00;

   assign disp_on     = {st_r.on, st_l.on};
   assign start_line0 = st_l.start;
   assign start_line1 = st_r.start;
   assign fb_rdata    = fb_rdata_q;
   assign txn_strobe  = txn_strobe_q;
   assign bad_cmd     = bad_cmd_q;

endmodule

// File: tb/tb_glcd_bus_responder.sv
// Directed bench for glcd_bus_responder: bus transactions through the interface,
// frame-buffer checks via the scoreboard port, pulses counted by a negedge monitor.
module tb_glcd_bus_responder;
   import glcd_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] disp_on;
   logic [5:0] start_line0, start_line1;
   logic [2:0] fb_page;
   logic [6:0] fb_col;
   logic [7:0] fb_rdata;
   logic       txn_strobe, bad_cmd;

   int checks = 0;
   int errors = 0;
   int txn_cnt = 0;
   int bad_cnt = 0;

   always #5 clk = ~clk;

   glcd_bus_responder_if bus ();

   glcd_bus_responder #(.SYNC_STAGES(2), .CS_ACTIVE_HIGH(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .disp_on     (disp_on),
      .start_line0 (start_line0),
      .start_line1 (start_line1),
      .fb_page     (fb_page),
      .fb_col      (fb_col),
      .fb_rdata    (fb_rdata),
      .txn_strobe  (txn_strobe),
      .bad_cmd     (bad_cmd)
   );

   always @(negedge clk) begin
      if (txn_strobe) txn_cnt++;
      if (bad_cmd)    bad_cnt++;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_txn(input logic rs, input logic rw, input logic c1, input logic c2,
                          input logic [7:0] d, output logic [7:0] dout, output logic doe);
      bus.lcd_rs   = rs;
      bus.lcd_rw   = rw;
      bus.cs1      = c1;
      bus.cs2      = c2;
      bus.lcd_data = d;
      repeat (2) @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (5) @(negedge clk);
      dout = bus.lcd_dout;
      doe  = bus.lcd_doe;
      bus.lcd_e = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic cmd(input logic c1, input logic c2, input logic [7:0] d);
      logic [7:0] dd;
      logic       oe;
      bus_txn(1'b0, 1'b0, c1, c2, d, dd, oe);
   endtask

   task automatic wr(input logic c1, input logic c2, input logic [7:0] d);
      logic [7:0] dd;
      logic       oe;
      bus_txn(1'b1, 1'b0, c1, c2, d, dd, oe);
   endtask

   task automatic rd(input logic rs, input logic c1, input logic c2,
                     output logic [7:0] dout, output logic doe);
      bus_txn(rs, 1'b1, c1, c2, 8'h00, dout, doe);
   endtask

   task automatic peek(input logic [2:0] p, input logic [6:0] c, output logic [7:0] v);
      fb_page = p;
      fb_col  = c;
      repeat (2) @(negedge clk);
      v = fb_rdata;
   endtask

   initial begin
      logic [7:0] v;
      logic       oe;
      int         base;

      bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0;
      bus.cs1 = 1'b0; bus.cs2 = 1'b0; bus.lcd_data = 8'h00;
      fb_page = 3'd0; fb_col = 7'd0;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_disp_on", 16'(disp_on), 16'h0);
      check("rst_start0", 16'(start_line0), 16'h0);
      check("rst_start1", 16'(start_line1), 16'h0);
      check("rst_strobes", {14'h0, txn_strobe, bad_cmd}, 16'h0);
      check("rst_doe_dout", {7'h0, bus.lcd_doe, bus.lcd_dout}, 16'h0);
      check("rst_fb_rdata", 16'(fb_rdata), 16'h0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // First status read: display off, reset flag still set.
      base = txn_cnt;
      rd(1'b0, 1'b1, 1'b0, v, oe);
      check("status_after_reset", 16'(v), 16'h0030);
      check("doe_during_read", 16'(oe), 16'h1);
      check("doe_after_read", 16'(bus.lcd_doe), 16'h0);
      check("txn_one_pulse", 16'(txn_cnt - base), 16'h1);

      base = txn_cnt;
      cmd(1'b1, 1'b1, 8'h3F);
      check("disp_on_both", 16'(disp_on), 16'h3);
      check("txn_on_cmd", 16'(txn_cnt - base), 16'h1);
      rd(1'b0, 1'b1, 1'b0, v, oe);
      check("status_on_flag_clr", 16'(v), 16'h0000);

      // Marker at fb[7][0] so the right-half write can be shown not to touch it.
      cmd(1'b1, 1'b0, 8'hBF);
      cmd(1'b1, 1'b0, 8'h40);
      wr(1'b1, 1'b0, 8'h11);

      cmd(1'b1, 1'b0, 8'hBB);
      cmd(1'b1, 1'b0, 8'h7E);
      wr(1'b1, 1'b0, 8'hAA);
      wr(1'b1, 1'b0, 8'h55);
      wr(1'b1, 1'b0, 8'h0F);
      peek(3'd3, 7'd62, v); check("fb_3_62", 16'(v), 16'h00AA);
      peek(3'd3, 7'd63, v); check("fb_3_63", 16'(v), 16'h0055);
      peek(3'd3, 7'd0,  v); check("fb_3_0_wrap", 16'(v), 16'h000F);

      cmd(1'b0, 1'b1, 8'hBF);
      cmd(1'b0, 1'b1, 8'h40);
      wr(1'b0, 1'b1, 8'h81);
      peek(3'd7, 7'd64, v); check("fb_7_64", 16'(v), 16'h0081);
      peek(3'd7, 7'd0,  v); check("fb_7_0_untouched", 16'(v), 16'h0011);

      base = txn_cnt;
      cmd(1'b1, 1'b1, 8'hB9);
      cmd(1'b1, 1'b1, 8'h45);
      wr(1'b1, 1'b1, 8'hC3);
      check("txn_both_halves", 16'(txn_cnt - base), 16'h3);
      wr(1'b1, 1'b1, 8'h3C);
      peek(3'd1, 7'd5,  v); check("fb_1_5",  16'(v), 16'h00C3);
      peek(3'd1, 7'd69, v); check("fb_1_69", 16'(v), 16'h00C3);
      peek(3'd1, 7'd6,  v); check("fb_1_6_y_inc",  16'(v), 16'h003C);
      peek(3'd1, 7'd70, v); check("fb_1_70_y_inc", 16'(v), 16'h003C);

      // Dummy-read rule: first read after addressing returns the stale latch.
      cmd(1'b1, 1'b0, 8'hBA);
      cmd(1'b1, 1'b0, 8'h4A);
      wr(1'b1, 1'b0, 8'h5A);
      cmd(1'b1, 1'b0, 8'h4A);
      rd(1'b1, 1'b1, 1'b0, v, oe);
      check("data_read_stale", 16'(v), 16'h0000);
      rd(1'b1, 1'b1, 1'b0, v, oe);
      check("data_read_5A", 16'(v), 16'h005A);
      check("data_read_doe", 16'(oe), 16'h1);

      cmd(1'b0, 1'b1, 8'hC5);
      check("start_line1", 16'(start_line1), 16'h5);
      check("start_line0_kept", 16'(start_line0), 16'h0);
      cmd(1'b1, 1'b0, 8'h3E);
      check("disp_left_off", 16'(disp_on), 16'h2);
      rd(1'b0, 1'b1, 1'b0, v, oe); check("status_left_off", 16'(v), 16'h0020);
      rd(1'b0, 1'b1, 1'b1, v, oe); check("status_both_left", 16'(v), 16'h0020);
      rd(1'b0, 1'b0, 1'b1, v, oe); check("status_right_on", 16'(v), 16'h0000);

      base = bad_cnt;
      cmd(1'b1, 1'b0, 8'h12);
      check("bad_cmd_pulse", 16'(bad_cnt - base), 16'h1);
      check("bad_cmd_disp", 16'(disp_on), 16'h2);
      check("bad_cmd_start", {4'h0, start_line1, start_line0}, {4'h0, 6'd5, 6'd0});

      base = txn_cnt;
      cmd(1'b0, 1'b0, 8'h3F);
      check("no_cs_ignored", {14'(txn_cnt - base), disp_on}, 16'h0002);

      // Reset with E high: the later fall of E must not be taken as a write to fb[0][0].
      cmd(1'b1, 1'b0, 8'hB8);
      cmd(1'b1, 1'b0, 8'h40);
      wr(1'b1, 1'b0, 8'h77);
      bus.lcd_rs = 1'b1; bus.lcd_rw = 1'b0; bus.cs1 = 1'b1; bus.cs2 = 1'b0;
      bus.lcd_data = 8'hEE;
      repeat (2) @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_disp_off", 16'(disp_on), 16'h0);
      base = txn_cnt;
      reset = 1'b1;
      repeat (6) @(negedge clk);
      bus.lcd_e = 1'b0;
      repeat (8) @(negedge clk);
      check("midrst_no_txn", 16'(txn_cnt - base), 16'h0);
      peek(3'd0, 7'd0, v); check("midrst_fb_kept", 16'(v), 16'h0077);
      rd(1'b0, 1'b1, 1'b0, v, oe);
      check("midrst_status", 16'(v), 16'h0030);
      check("midrst_txn_after", 16'(txn_cnt - base), 16'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
